// File: rtl/conv_row_loader.sv
// Pixel-stream row packer for the 3x3 convolution engine: collects ROW_PIXELS pixels per row,
// writes each row to the input row RAM, then holds in RUN until the output side reports done.
module conv_row_loader #(
   parameter int PIXEL_W    = 8,
   parameter int ROW_PIXELS = 130,
   parameter int ROWS       = 130,
   localparam int ROW_W     = PIXEL_W * ROW_PIXELS,
   localparam int ADDR_W    = $clog2(ROWS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [PIXEL_W-1:0] in_data,
   output logic              in_ready,
   input  logic              conv_done,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [ROW_W-1:0]  ram_wdata,
   output logic              conv_run
);

   localparam int COL_W = $clog2(ROW_PIXELS);
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(ROW_PIXELS - 1);
   localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, FILL, WRITE, RUN} state_t;

   state_t              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ADDR_W-1:0]   row_q, row_d;
   logic [ROW_W-1:0]    buf_q, buf_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ROW_W-1:0]    wdata_q, wdata_d;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      buf_d    = buf_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      in_ready = (state_q == FILL);
      ram_we   = (state_q == WRITE);
      conv_run = (state_q == RUN);

      unique case (state_q)
         IDLE: state_d = FILL;
         FILL: begin
            if (in_valid) begin
               buf_d[int'(col_q) * PIXEL_W +: PIXEL_W] = in_data;
               if (col_q == COL_LAST) begin
                  // Capture the completed row, including this last pixel, for the write cycle.
                  col_d   = '0;
                  addr_d  = row_q;
                  wdata_d = buf_d;
                  state_d = WRITE;
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         WRITE: begin
            if (row_q == ROW_LAST) begin
               row_d   = '0;
               state_d = RUN;
            end else begin
               row_d   = row_q + ADDR_W'(1);
               state_d = FILL;
            end
         end
         RUN: if (conv_done) state_d = FILL;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the row register is reset along with the control state so ram_wdata reads 0 out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         buf_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values computed above.
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         buf_q   <= buf_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_conv_row_loader.sv
// Directed-plus-random bench for conv_row_loader, checked every cycle against a
// transaction-level model of the row packer (pixel counts, row index, run flag).
module tb_conv_row_loader;

   localparam int PIXEL_W    = 8;
   localparam int ROW_PIXELS = 130;
   localparam int ROWS       = 130;
   localparam int ROW_W      = PIXEL_W * ROW_PIXELS;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic [7:0]       in_data = '0;
   logic             conv_done = 1'b0;
   logic             in_ready, ram_we, conv_run;
   logic [7:0]       ram_addr;
   logic [ROW_W-1:0] ram_wdata;

   always #5 clk = ~clk;

   conv_row_loader #(.PIXEL_W(PIXEL_W), .ROW_PIXELS(ROW_PIXELS), .ROWS(ROWS)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .conv_done (conv_done),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .conv_run  (conv_run)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: what has been accepted so far and what the loader should be doing.
   bit               m_idle, m_we, m_run;
   int               m_col, m_row;
   logic [7:0]       m_pix [ROW_PIXELS];
   logic [7:0]       m_addr;
   logic [ROW_W-1:0] m_wdata;

   logic [7:0]       stim [ROW_PIXELS];
   int               we_seen;
   int               addr_log [$];

   task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [ROW_W-1:0] pack_row();
      logic [ROW_W-1:0] w = '0;
      for (int c = 0; c < ROW_PIXELS; c++) w[c*8 +: 8] = m_pix[c];
      return w;
   endfunction

   function automatic bit m_ready();
      return !m_idle && !m_we && !m_run;
   endfunction

   task automatic model_reset();
      m_idle  = 1'b1;
      m_we    = 1'b0;
      m_run   = 1'b0;
      m_col   = 0;
      m_row   = 0;
      m_addr  = '0;
      m_wdata = '0;
      for (int c = 0; c < ROW_PIXELS; c++) m_pix[c] = '0;
   endtask

   task automatic model_edge(input bit v, input logic [7:0] d, input bit dn);
      if (!reset) begin
         model_reset();
      end else if (m_idle) begin
         m_idle = 1'b0;
      end else if (m_we) begin
         m_we = 1'b0;
         if (m_row == ROWS - 1) begin
            m_row = 0;
            m_run = 1'b1;
         end else begin
            m_row++;
         end
      end else if (m_run) begin
         if (dn) m_run = 1'b0;
      end else if (v) begin
         m_pix[m_col] = d;
         m_col++;
         if (m_col == ROW_PIXELS) begin
            m_col   = 0;
            m_we    = 1'b1;
            m_addr  = 8'(m_row);
            m_wdata = pack_row();
         end
      end
   endtask

   // Drive one cycle's inputs at the falling edge, compare outputs, then advance the model.
   task automatic cycle(input bit v, input logic [7:0] d, input bit dn);
      in_valid  = v;
      in_data   = d;
      conv_done = dn;
      check("ctrl{ready,we,run,addr}", {in_ready, ram_we, conv_run, ram_addr},
            {m_ready(), m_we, m_run, m_addr});
      check("wdata", ram_wdata, m_wdata);
      if (ram_we === 1'b1) begin
         we_seen++;
         addr_log.push_back(int'(ram_addr));
      end
      @(posedge clk);
      model_edge(v, d, dn);
      @(negedge clk);
   endtask

   task automatic send_pixels(input int n, input bit gaps, input bit done_noise);
      int c = 0;
      int guard = 0;
      while (c < n && guard < 4000) begin
         bit v    = gaps ? ($urandom_range(2, 0) != 0) : 1'b1;
         bit dn   = done_noise ? ($urandom_range(3, 0) == 0) : 1'b0;
         bit take = v && m_ready();
         cycle(v, v ? stim[c] : 8'($urandom), dn);
         if (take) c++;
         guard++;
      end
   endtask

   task automatic reset_cycles(input int n);
      reset = 1'b0;
      repeat (n) cycle(1'b0, 8'h00, 1'b0);
      reset = 1'b1;
   endtask

   initial begin
      model_reset();
      @(negedge clk);

      // Reset held for 3 cycles, then the IDLE cycle ignores a valid pixel.
      reset_cycles(3);
      cycle(1'b1, 8'h12, 1'b0);

      // Single row 0x00..0x81, continuous valid.
      for (int c = 0; c < ROW_PIXELS; c++) stim[c] = 8'(c);
      we_seen = 0;
      send_pixels(ROW_PIXELS, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 8'h00, 1'b0);
      check("row0_we_pulses", 32'(we_seen), 32'd1);
      check("row0_addr", ram_addr, 8'h00);
      check("row0_first_px", ram_wdata[7:0], 8'h00);
      check("row0_last_px", ram_wdata[ROW_W-1 -: 8], 8'h81);

      // Same row with random valid gaps and conv_done noise; then 0xFF-heavy random row.
      send_pixels(ROW_PIXELS, 1'b1, 1'b1);
      repeat (2) cycle(1'b0, 8'h00, 1'b1);
      check("row1_addr", ram_addr, 8'h01);
      for (int c = 0; c < ROW_PIXELS; c++) stim[c] = (c % 3 == 0) ? 8'hFF : 8'($urandom);
      send_pixels(ROW_PIXELS, 1'b1, 1'b1);
      repeat (2) cycle(1'b0, 8'h00, 1'b0);
      check("row2_ff_px", ram_wdata[7:0], 8'hFF);

      // Full frame: row r filled with r, conv_done noise on early rows.
      reset_cycles(2);
      addr_log.delete();
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < ROW_PIXELS; c++) stim[c] = 8'(r);
         send_pixels(ROW_PIXELS, r == 7, r < 3);
      end
      cycle(1'b1, 8'h33, 1'b0);
      repeat (50) cycle(1'b1, 8'($urandom), 1'b0);
      check("frame_run", {31'd0, conv_run}, 32'd1);
      check("frame_writes", 32'(addr_log.size()), 32'(ROWS));
      for (int i = 0; i < addr_log.size() && i < ROWS; i++)
         check($sformatf("frame_addr_%0d", i), 32'(addr_log[i]), 32'(i));

      // conv_done releases RUN; next row lands at address 0.
      cycle(1'b0, 8'h00, 1'b1);
      for (int c = 0; c < ROW_PIXELS; c++) stim[c] = 8'h5A;
      send_pixels(ROW_PIXELS, 1'b0, 1'b0);
      repeat (2) cycle(1'b0, 8'h00, 1'b0);
      check("rerun_addr", ram_addr, 8'h00);

      // Reset mid-frame at row 5, column 60, asserted between clock edges.
      reset_cycles(1);
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < ROW_PIXELS; c++) stim[c] = 8'($urandom);
         send_pixels(ROW_PIXELS, 1'b0, 1'b0);
      end
      send_pixels(60, 1'b0, 1'b0);
      check("pre_reset_addr", ram_addr, 8'h04);
      reset = 1'b0;
      #1;
      check("async_rst_ready", {31'd0, in_ready}, 32'd0);
      check("async_rst_we", {31'd0, ram_we}, 32'd0);
      check("async_rst_run", {31'd0, conv_run}, 32'd0);
      check("async_rst_addr", ram_addr, 8'h00);
      check("async_rst_wdata", ram_wdata, '0);
      model_reset();
      @(negedge clk);
      reset_cycles(2);
      for (int c = 0; c < ROW_PIXELS; c++) stim[c] = 8'hAA;
      send_pixels(ROW_PIXELS, 1'b1, 1'b0);
      repeat (2) cycle(1'b0, 8'h00, 1'b0);
      check("post_reset_addr", ram_addr, 8'h00);
      check("post_reset_wdata", ram_wdata, {ROW_PIXELS{8'hAA}});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
